unified_mem_arbiter: RTL and testbench

Single-port memory arbiter for the 16-bit pipelined processor. It shares one synchronous single-port SRAM between three requesters:
- instruction fetch (IM)
- data access (DM)
- a host load/dump port used to preload programs and read back results while the core is halted

It sits between the pipelinedPS memory ports and the SRAM. Stalls are expressed through per-requester grants.

---
 rtl/unified_mem_if.sv | 56 +++++
 rtl/unified_mem_arbiter.sv | 91 +++++++++
 tb/tb_unified_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_if.sv
// Bundle between the three memory requesters, the shared single-port SRAM and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/SRAM side.
interface unified_mem_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16
);
   logic                  cpu_halt;
   logic                  im_req;
   logic [ADDR_WIDTH-1:0] im_addr;
   logic                  im_gnt;
   logic                  im_r_valid;
   logic                  dm_req;
   logic                  dm_we;
   logic [ADDR_WIDTH-1:0] dm_addr;
   logic [DATA_WIDTH-1:0] dm_w_data;
   logic                  dm_gnt;
   logic                  dm_r_valid;
   logic                  host_req;
   logic                  host_we;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_w_data;
   logic                  host_gnt;
   logic                  host_r_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd;
   logic                  mem_wr;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic [DATA_WIDTH-1:0] mem_r_data;
   logic [DATA_WIDTH-1:0] r_data;

   modport slave (
      input  cpu_halt,
      input  im_req, im_addr,
      output im_gnt, im_r_valid,
      input  dm_req, dm_we, dm_addr, dm_w_data,
      output dm_gnt, dm_r_valid,
      input  host_req, host_we, host_addr, host_w_data,
      output host_gnt, host_r_valid,
      output mem_addr, mem_rd, mem_wr, mem_w_data,
      input  mem_r_data,
      output r_data
   );

   modport master (
      output cpu_halt,
      output im_req, im_addr,
      input  im_gnt, im_r_valid,
      output dm_req, dm_we, dm_addr, dm_w_data,
      input  dm_gnt, dm_r_valid,
      output host_req, host_we, host_addr, host_w_data,
      input  host_gnt, host_r_valid,
      input  mem_addr, mem_rd, mem_wr, mem_w_data,
      output mem_r_data,
      input  r_data
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch, data access and a host load/dump port.
//   state | meaning
//   CPU   | IM/DM arbitration, DM preferred unless IM has starved STARVE_MAX cycles
//   DRAIN | one idle cycle so a CPU read in flight returns before the host takes over
//   HOST  | host owns the SRAM until it drops host_req
module unified_mem_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst,
   unified_mem_if.slave bus
);
   typedef enum logic [1:0] {ST_CPU, ST_DRAIN, ST_HOST} state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_IM, TAG_DM, TAG_HOST} tag_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state;
   logic [3:0] starve_cnt;
   tag_t       rtag;
   tag_t       rd_tag;
   logic       cpu_arb;
   logic       im_win;
   logic       im_gnt;
   logic       dm_gnt;
   logic       host_gnt;

   // HOST with host_req low hands back to the CPU within the same cycle.
   always_comb begin
      cpu_arb  = (state == ST_CPU) || ((state == ST_HOST) && !bus.host_req);
      im_win   = bus.im_req && (!bus.dm_req || (starve_cnt == STARVE_LIM));
      im_gnt   = cpu_arb && im_win;
      dm_gnt   = cpu_arb && bus.dm_req && !im_win;
      host_gnt = (state == ST_HOST) && bus.host_req;
   end

   always_comb begin
      bus.mem_addr   = '0;
      bus.mem_rd     = 1'b0;
      bus.mem_wr     = 1'b0;
      bus.mem_w_data = '0;
      rd_tag         = TAG_NONE;
      if (im_gnt) begin
         bus.mem_addr = bus.im_addr;
         bus.mem_rd   = 1'b1;
         rd_tag       = TAG_IM;
      end else if (dm_gnt) begin
         bus.mem_addr   = bus.dm_addr;
         bus.mem_rd     = !bus.dm_we;
         bus.mem_wr     = bus.dm_we;
         bus.mem_w_data = bus.dm_w_data;
         rd_tag         = bus.dm_we ? TAG_NONE : TAG_DM;
      end else if (host_gnt) begin
         bus.mem_addr   = bus.host_addr;
         bus.mem_rd     = !bus.host_we;
         bus.mem_wr     = bus.host_we;
         bus.mem_w_data = bus.host_w_data;
         rd_tag         = bus.host_we ? TAG_NONE : TAG_HOST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_CPU;
         starve_cnt <= '0;
         rtag       <= TAG_NONE;
      end else begin
         case (state)
            ST_CPU:   if (bus.host_req && bus.cpu_halt) state <= ST_DRAIN;
            ST_DRAIN: state <= ST_HOST;
            ST_HOST:  if (!bus.host_req) state <= ST_CPU;
            default:  state <= ST_CPU;
         endcase
         if (!bus.im_req || im_gnt)
            starve_cnt <= '0;
         else if (starve_cnt < STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
         rtag <= rd_tag;
      end
   end

   assign bus.im_gnt       = im_gnt;
   assign bus.dm_gnt       = dm_gnt;
   assign bus.host_gnt     = host_gnt;
   assign bus.im_r_valid   = (rtag == TAG_IM);
   assign bus.dm_r_valid   = (rtag == TAG_DM);
   assign bus.host_r_valid = (rtag == TAG_HOST);
   assign bus.r_data       = bus.mem_r_data;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: grants checked inline, read returns checked by a
// scoreboard monitor against expectations queued when each read grant is issued.
module tb_unified_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 16;

   localparam logic [1:0] OWN_IM   = 2'd1;
   localparam logic [1:0] OWN_DM   = 2'd2;
   localparam logic [1:0] OWN_HOST = 2'd3;

   typedef struct packed {
      logic [1:0]    owner;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   unified_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

   unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_MAX(3)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // SRAM model: preloaded with 0x1000+addr while reset is high.
   logic [DW-1:0] sram [0:255];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) sram[i] <= DW'(16'h1000 + i);
      end else if (bus.mem_wr) begin
         sram[bus.mem_addr] <= bus.mem_w_data;
      end
      if (bus.mem_rd) bus.mem_r_data <= sram[bus.mem_addr];
   end

   exp_t          q[$];
   logic [DW-1:0] exp_mem [0:255];
   int            vectors = 0;
   int            miscompares = 0;
   logic          mon_en = 1'b0;
   logic          done = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic expect_gnt(string name, logic [2:0] req);
      check(name, 32'({bus.im_gnt, bus.dm_gnt, bus.host_gnt}), 32'(req));
   endtask

   task automatic push(logic [1:0] owner, logic [DW-1:0] data);
      exp_t e;
      e.owner = owner;
      e.data  = data;
      q.push_back(e);
   endtask

   task automatic idle_inputs();
      bus.im_req = 1'b0;      bus.im_addr = '0;
      bus.dm_req = 1'b0;      bus.dm_we = 1'b0;   bus.dm_addr = '0;   bus.dm_w_data = '0;
      bus.host_req = 1'b0;    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_w_data = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor, sampled mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (mon_en && !done) begin
         int   nv;
         int   ng;
         exp_t e;
         logic [1:0] own;
         nv = int'(bus.im_r_valid) + int'(bus.dm_r_valid) + int'(bus.host_r_valid);
         ng = int'(bus.im_gnt) + int'(bus.dm_gnt) + int'(bus.host_gnt);
         check("rvalid_onehot", 32'(nv <= 1), 1);
         check("gnt_onehot", 32'(ng <= 1), 1);
         if (nv != 0) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_rvalid: got im/dm/host %b%b%b expected none at %0t",
                        bus.im_r_valid, bus.dm_r_valid, bus.host_r_valid, $time);
            end else begin
               e   = q.pop_front();
               own = bus.im_r_valid ? OWN_IM : (bus.dm_r_valid ? OWN_DM : OWN_HOST);
               check("rvalid_owner", 32'(own), 32'(e.owner));
               check("r_data", 32'(bus.r_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = DW'(16'h1000 + i);
      rst = 1'b1;
      bus.cpu_halt = 1'b0;
      idle_inputs();

      // Reset then idle
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         mon_en = 1'b1;
         #2;
         expect_gnt("reset_gnt", 3'b000);
         check("reset_mem_rdwr", 32'({bus.mem_rd, bus.mem_wr}), 0);
         check("reset_rvalid", 32'({bus.im_r_valid, bus.dm_r_valid, bus.host_r_valid}), 0);
      end

      // IM-only stream
      for (int a = 0; a < 3; a++) begin
         next_cycle();
         rst = 1'b0;
         bus.im_req = 1'b1;
         bus.im_addr = AW'(a);
         #2;
         expect_gnt("im_stream_gnt", 3'b100);
         check("im_stream_addr", 32'({bus.mem_rd, bus.mem_addr}), 32'({1'b1, AW'(a)}));
         push(OWN_IM, exp_mem[a]);
      end
      next_cycle();
      idle_inputs();
      #2;
      expect_gnt("idle_gnt", 3'b000);

      // Contention: DM three cycles, then starved IM wins
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         bus.im_req = 1'b1;  bus.im_addr = 8'h05;
         bus.dm_req = 1'b1;  bus.dm_we = 1'b0;  bus.dm_addr = 8'h0A;
         #2;
         if (i % 4 == 3) begin
            expect_gnt("starve_gnt", 3'b100);
            push(OWN_IM, exp_mem[5]);
         end else begin
            expect_gnt("starve_gnt", 3'b010);
            push(OWN_DM, exp_mem[10]);
         end
      end

      // DM write then read back
      next_cycle();
      idle_inputs();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 8'h03; bus.dm_w_data = 16'h00A0;
      #2;
      expect_gnt("dm_wr_gnt", 3'b010);
      check("dm_wr_bus", 32'({bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_w_data}),
            32'({1'b1, 1'b0, 8'h03, 16'h00A0}));
      exp_mem[3] = 16'h00A0;
      next_cycle();
      bus.dm_we = 1'b0;
      #2;
      expect_gnt("dm_rd_gnt", 3'b010);
      check("dm_rd_mem_wr", 32'(bus.mem_wr), 0);
      push(OWN_DM, exp_mem[3]);

      // Host request while core running: host waits
      for (int c = 0; c < 2; c++) begin
         next_cycle();
         idle_inputs();
         bus.im_req = 1'b1; bus.im_addr = 8'h06;
         bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h04; bus.host_w_data = 16'hFFF6;
         bus.cpu_halt = 1'b0;
         #2;
         expect_gnt("host_wait_gnt", 3'b100);
         push(OWN_IM, exp_mem[6]);
      end
      next_cycle();
      bus.cpu_halt = 1'b1;
      #2;
      expect_gnt("halt_edge_gnt", 3'b100);
      push(OWN_IM, exp_mem[6]);
      next_cycle();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'h02;
      #2;
      expect_gnt("drain_gnt", 3'b000);
      check("drain_mem_rdwr", 32'({bus.mem_rd, bus.mem_wr}), 0);
      next_cycle();
      #2;
      expect_gnt("host_wr_gnt", 3'b001);
      check("host_wr_bus", 32'({bus.mem_wr, bus.mem_addr, bus.mem_w_data}),
            32'({1'b1, 8'h04, 16'hFFF6}));
      exp_mem[4] = 16'hFFF6;
      next_cycle();
      bus.host_we = 1'b0;
      bus.cpu_halt = 1'b0;
      #2;
      expect_gnt("host_rd_gnt", 3'b001);
      push(OWN_HOST, exp_mem[4]);
      next_cycle();
      bus.host_req = 1'b0;
      bus.dm_req = 1'b0;
      bus.im_addr = 8'h07;
      #2;
      expect_gnt("host_release_gnt", 3'b100);
      push(OWN_IM, exp_mem[7]);
      next_cycle();
      idle_inputs();
      #2;
      expect_gnt("post_host_idle", 3'b000);

      // Reset mid-read: granted read is dropped
      next_cycle();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 8'h01;
      rst = 1'b1;
      #2;
      expect_gnt("rst_mid_gnt", 3'b010);
      next_cycle();
      idle_inputs();
      rst = 1'b0;
      #2;
      expect_gnt("rst_after_gnt", 3'b000);
      check("rst_after_rvalid", 32'({bus.im_r_valid, bus.dm_r_valid, bus.host_r_valid}), 0);
      check("rst_after_mem", 32'({bus.mem_rd, bus.mem_wr}), 0);
      next_cycle();
      #2;
      check("scoreboard_drained", 32'(q.size()), 0);
      @(negedge clk);
      #1;
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
